// File: rtl/sd_to_binary_serial.sv
// sd_to_binary_serial: bit-serial signed-digit to two's-complement converter with valid/ready handshakes
module sd_to_binary_serial #(
  parameter int N  = 8,
  parameter int CW = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_pos,
  input  logic [N-1:0] in_neg,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   out_data,
  output logic         out_err
);
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  state_t        state_q, state_d;
  logic [N-1:0]  p_q, p_d, q_q, q_d, acc_q, acc_d, acc_n;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          b_q, b_d, err_q, err_d, oerr_q, oerr_d, r, bn;
  logic [N:0]    data_q, data_d;
  // One serial subtract step: P minus Q with a rippling borrow, LSB first
  always_comb begin
    r     = p_q[0] ^ q_q[0] ^ b_q;
    bn    = (~p_q[0] & q_q[0]) | (~(p_q[0] ^ q_q[0]) & b_q);
    acc_n = {r, acc_q[N-1:1]};
  end
  // Next-state logic for the handshake FSM and the conversion datapath
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    q_d     = q_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    b_d     = b_q;
    err_d   = err_q;
    oerr_d  = oerr_q;
    data_d  = data_q;
    case (state_q)
      IDLE: if (in_valid) begin
        p_d     = in_pos & ~in_neg;
        q_d     = in_neg & ~in_pos;
        err_d   = |(in_pos & in_neg);
        b_d     = 1'b0;
        cnt_d   = '0;
        acc_d   = '0;
        state_d = CONV;
      end
      CONV: begin
        p_d   = p_q >> 1;
        q_d   = q_q >> 1;
        b_d   = bn;
        acc_d = acc_n;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          data_d  = {bn, acc_n};
          oerr_d  = err_q;
          state_d = DONE;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // State and output registers; reset aborts any word in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      p_q     <= '0;
      q_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      b_q     <= 1'b0;
      err_q   <= 1'b0;
      oerr_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      q_q     <= q_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      b_q     <= b_d;
      err_q   <= err_d;
      oerr_q  <= oerr_d;
      data_q  <= data_d;
    end
  end
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = data_q;
  assign out_err   = oerr_q;
endmodule
